// File: rtl/frmbuf_cfg_master.sv
// AXI4-Lite master that programs, page-flips and stops the frame buffer read core.
// Define FRMBUF_CFG_READBACK_EN to verify each non-CTRL register by reading it back.
module frmbuf_cfg_master #(
  parameter logic [31:0] BASE_ADDR    = 32'h43C0_0000,
  parameter int unsigned PIXEL_BYTES  = 4,
  parameter logic [31:0] VIDEO_FORMAT = 32'd20,
  parameter logic [31:0] CTRL_START   = 32'h81
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cfg_start_i,
  input  logic        cfg_stop_i,
  input  logic [15:0] cfg_width_i,
  input  logic [15:0] cfg_height_i,
  input  logic [31:0] cfg_fb_addr_i,
  input  logic        flip_req_i,
  input  logic [31:0] flip_addr_i,
  input  logic        frame_done_i,
  output logic        busy_o,
  output logic        running_o,
  output logic        error_o,
  output logic        flip_ack_o,
  output logic [31:0] m_axi_awaddr_o,
  output logic        m_axi_awvalid_o,
  input  logic        m_axi_awready_i,
  output logic [31:0] m_axi_wdata_o,
  output logic [3:0]  m_axi_wstrb_o,
  output logic        m_axi_wvalid_o,
  input  logic        m_axi_wready_i,
  input  logic [1:0]  m_axi_bresp_i,
  input  logic        m_axi_bvalid_i,
  output logic        m_axi_bready_o,
  output logic [31:0] m_axi_araddr_o,
  output logic        m_axi_arvalid_o,
  input  logic        m_axi_arready_i,
  input  logic [31:0] m_axi_rdata_i,
  input  logic [1:0]  m_axi_rresp_i,
  input  logic        m_axi_rvalid_i,
  output logic        m_axi_rready_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RESP,
`ifdef FRMBUF_CFG_READBACK_EN
    S_RDADDR,
    S_RDDATA,
`endif
    S_RUN
  } state_t;

  localparam logic [2:0] IDX_CTRL = 3'd5;
  localparam logic [2:0] IDX_FLIP = 3'd6;
  localparam logic [2:0] IDX_STOP = 3'd7;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        err_q, err_d;
  logic        run_q, run_d;
  logic        ack_q, ack_d;
  logic        pend_q, pend_d;
  logic        stop_q, stop_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [31:0] fb_q, fb_d;
  logic [31:0] pend_addr_q, pend_addr_d;
  logic [31:0] flip_wr_q, flip_wr_d;

  logic [31:0] stride;
  logic [7:0]  wr_off;
  logic [31:0] wr_data;
  logic [31:0] wr_addr;
  logic        adv;
  logic        fail;

  assign stride = {16'd0, width_q} * PIXEL_BYTES;

  // Register offset and value for the write currently selected by idx.
  always_comb begin
    wr_off  = 8'h00;
    wr_data = 32'd0;
    case (idx_q)
      3'd0:     begin wr_off = 8'h10; wr_data = {16'd0, width_q};  end
      3'd1:     begin wr_off = 8'h18; wr_data = {16'd0, height_q}; end
      3'd2:     begin wr_off = 8'h20; wr_data = stride;            end
      3'd3:     begin wr_off = 8'h28; wr_data = VIDEO_FORMAT;      end
      3'd4:     begin wr_off = 8'h30; wr_data = fb_q;              end
      IDX_CTRL: begin wr_off = 8'h00; wr_data = CTRL_START;        end
      IDX_FLIP: begin wr_off = 8'h30; wr_data = flip_wr_q;         end
      default:  begin wr_off = 8'h00; wr_data = 32'd0;             end
    endcase
  end

  assign wr_addr = BASE_ADDR + {24'd0, wr_off};

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_d       = err_q;
    run_d       = run_q;
    ack_d       = 1'b0;
    pend_d      = pend_q;
    stop_d      = stop_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    width_d     = width_q;
    height_d    = height_q;
    fb_d        = fb_q;
    pend_addr_d = pend_addr_q;
    flip_wr_d   = flip_wr_q;
    adv         = 1'b0;
    fail        = 1'b0;

    // A stop arriving mid-sequence is remembered until the core is back in RUN.
    if ((state_q != S_IDLE) && (state_q != S_RUN) && cfg_stop_i)
      stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_start_i) begin
          if ((cfg_width_i == 16'd0) || (cfg_height_i == 16'd0)) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            width_d   = cfg_width_i;
            height_d  = cfg_height_i;
            fb_d      = cfg_fb_addr_i;
            idx_d     = 3'd0;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        aw_done_d = aw_done_q | m_axi_awready_i;
        w_done_d  = w_done_q | m_axi_wready_i;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid_i) begin
          if (m_axi_bresp_i != 2'b00)
            fail = 1'b1;
`ifdef FRMBUF_CFG_READBACK_EN
          else if ((idx_q != IDX_CTRL) && (idx_q != IDX_STOP))
            state_d = S_RDADDR;
`endif
          else
            adv = 1'b1;
        end
      end
`ifdef FRMBUF_CFG_READBACK_EN
      S_RDADDR: begin
        if (m_axi_arready_i)
          state_d = S_RDDATA;
      end
      S_RDDATA: begin
        if (m_axi_rvalid_i) begin
          if ((m_axi_rresp_i != 2'b00) || (m_axi_rdata_i != wr_data))
            fail = 1'b1;
          else
            adv = 1'b1;
        end
      end
`endif
      S_RUN: begin
        if (cfg_stop_i || stop_q) begin
          pend_d  = 1'b0;
          stop_d  = 1'b0;
          idx_d   = IDX_STOP;
          state_d = S_WRITE;
        end else begin
          if (frame_done_i && pend_q) begin
            flip_wr_d = pend_addr_q;
            pend_d    = 1'b0;
            idx_d     = IDX_FLIP;
            state_d   = S_WRITE;
          end
          if (flip_req_i) begin
            pend_d      = 1'b1;
            pend_addr_d = flip_addr_i;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      err_d   = 1'b1;
      run_d   = 1'b0;
      pend_d  = 1'b0;
      stop_d  = 1'b0;
      state_d = S_IDLE;
    end else if (adv) begin
      case (idx_q)
        IDX_CTRL: begin run_d = 1'b1; state_d = S_RUN; end
        IDX_FLIP: begin ack_d = 1'b1; state_d = S_RUN; end
        IDX_STOP: begin run_d = 1'b0; stop_d = 1'b0; state_d = S_IDLE; end
        default:  begin idx_d = idx_q + 3'd1; state_d = S_WRITE; end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= 3'd0;
      err_q     <= 1'b0;
      run_q     <= 1'b0;
      ack_q     <= 1'b0;
      pend_q    <= 1'b0;
      stop_q    <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      err_q     <= err_d;
      run_q     <= run_d;
      ack_q     <= ack_d;
      pend_q    <= pend_d;
      stop_q    <= stop_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    width_q     <= width_d;
    height_q    <= height_d;
    fb_q        <= fb_d;
    pend_addr_q <= pend_addr_d;
    flip_wr_q   <= flip_wr_d;
  end

  assign busy_o          = (state_q != S_IDLE) && (state_q != S_RUN);
  assign running_o       = run_q;
  assign error_o         = err_q;
  assign flip_ack_o      = ack_q;
  assign m_axi_awvalid_o = (state_q == S_WRITE) && !aw_done_q;
  assign m_axi_wvalid_o  = (state_q == S_WRITE) && !w_done_q;
  assign m_axi_awaddr_o  = (state_q == S_WRITE) ? wr_addr : 32'd0;
  assign m_axi_wdata_o   = (state_q == S_WRITE) ? wr_data : 32'd0;
  assign m_axi_wstrb_o   = 4'hF;
  assign m_axi_bready_o  = (state_q == S_RESP);

`ifdef FRMBUF_CFG_READBACK_EN
  assign m_axi_arvalid_o = (state_q == S_RDADDR);
  assign m_axi_araddr_o  = (state_q == S_RDADDR) ? wr_addr : 32'd0;
  assign m_axi_rready_o  = (state_q == S_RDDATA);
`else
  logic unused_rd;
  assign unused_rd       = ^{m_axi_rdata_i, m_axi_rresp_i, m_axi_rvalid_i, m_axi_arready_i};
  assign m_axi_arvalid_o = 1'b0;
  assign m_axi_araddr_o  = 32'd0;
  assign m_axi_rready_o  = 1'b0;
`endif

endmodule
